wave_measure: RTL and testbench

WAVE_MEASURE -- requirements
Module: wave_measure

---
 rtl/wave_measure.sv | 112 +++++++++++
 tb/tb_wave_measure.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_measure.sv
// Period and min/max of an 8-bit waveform between rising mid-level crossings; define WAVE_MEAS_HYST_EN for +/-HYST hysteresis.
// Results land one cycle after the closing crossing sample; no backpressure, sample_valid only qualifies data.
module wave_measure #(
   parameter int CNT_WIDTH = 24,
   parameter int MID_LEVEL = 128,
   parameter int HYST      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_valid,
   input  logic [7:0]           sample_data,
   output logic                 meas_valid,
   output logic [CNT_WIDTH-1:0] period,
   output logic [7:0]           max_val,
   output logic [7:0]           min_val,
   output logic                 timeout
);

`ifdef WAVE_MEAS_HYST_EN
   localparam logic [8:0] LO_THR = 9'(MID_LEVEL - HYST);
   localparam logic [8:0] HI_THR = 9'(MID_LEVEL + HYST);
`else
   localparam logic [8:0] LO_THR = 9'(MID_LEVEL);
   localparam logic [8:0] HI_THR = 9'(MID_LEVEL);
`endif

   typedef enum logic [1:0] {ARM, WAIT_RISE, MEASURE} state_t;

   state_t               state;
   logic                 below;
   logic [CNT_WIDTH-1:0] cnt;
   logic [7:0]           run_max;
   logic [7:0]           run_min;

   logic [8:0]           smp;
   logic                 is_lo;
   logic                 is_event;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 cnt_sat;

   assign smp      = {1'b0, sample_data};
   assign is_lo    = sample_valid && (smp < LO_THR);
   assign is_event = sample_valid && below && (smp >= HI_THR);
   assign cnt_inc  = cnt + 1'b1;
   // Saturate one step early so cnt+1 always fits in the period register.
   assign cnt_sat  = (cnt_inc == '1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARM;
         below      <= 1'b0;
         cnt        <= '0;
         run_max    <= '0;
         run_min    <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         period     <= '0;
         max_val    <= '0;
         min_val    <= '0;
      end else begin
         meas_valid <= 1'b0;
         timeout    <= 1'b0;

         if (is_event)
            below <= 1'b0;
         else if (is_lo)
            below <= 1'b1;

         case (state)
            ARM: begin
               if (is_lo)
                  state <= WAIT_RISE;
            end
            WAIT_RISE: begin
               if (is_event) begin
                  cnt     <= '0;
                  run_max <= sample_data;
                  run_min <= sample_data;
                  state   <= MEASURE;
               end
            end
            MEASURE: begin
               if (cnt_sat) begin
                  // Timeout wins over a coincident crossing and drops the arm flag.
                  timeout <= 1'b1;
                  below   <= 1'b0;
                  cnt     <= '0;
                  state   <= ARM;
               end else if (is_event) begin
                  period     <= cnt_inc;
                  max_val    <= run_max;
                  min_val    <= run_min;
                  meas_valid <= 1'b1;
                  cnt        <= '0;
                  run_max    <= sample_data;
                  run_min    <= sample_data;
               end else begin
                  cnt <= cnt_inc;
                  if (sample_valid) begin
                     if (sample_data > run_max)
                        run_max <= sample_data;
                     if (sample_data < run_min)
                        run_min <= sample_data;
                  end
               end
            end
            default: state <= ARM;
         endcase
      end
   end

endmodule

// File: tb/tb_wave_measure.sv
// Bench for wave_measure: scenario vector table plus timeout and mid-measurement reset sequences.
// A 24-bit and an 8-bit counter instance share the same stimulus.
module tb_wave_measure;

   localparam int MID = 128;
   localparam int HYS = 8;
`ifdef WAVE_MEAS_HYST_EN
   localparam int LO_T = MID - HYS;
   localparam int HI_T = MID + HYS;
`else
   localparam int LO_T = MID;
   localparam int HI_T = MID;
`endif

   logic        clk;
   logic        rst_n;
   logic        sample_valid;
   logic [7:0]  sample_data;

   logic        meas_valid;
   logic [23:0] period;
   logic [7:0]  max_val;
   logic [7:0]  min_val;
   logic        timeout;

   logic        meas_valid8;
   logic [7:0]  period8;
   logic [7:0]  max_val8;
   logic [7:0]  min_val8;
   logic        timeout8;

   wave_measure #(.CNT_WIDTH(24), .MID_LEVEL(MID), .HYST(HYS)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .meas_valid(meas_valid), .period(period), .max_val(max_val), .min_val(min_val),
      .timeout(timeout)
   );

   wave_measure #(.CNT_WIDTH(8), .MID_LEVEL(MID), .HYST(HYS)) dut8 (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .meas_valid(meas_valid8), .period(period8), .max_val(max_val8), .min_val(min_val8),
      .timeout(timeout8)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int per;
      int mx;
      int mn;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int div;
      int reps;
      bit tail;
      int exp_cnt;
      int exp_per;
      int exp_max;
      int exp_min;
   } vec_t;
   vec_t vecs[3];

   int n_vec = 0;
   int n_bad = 0;
   int n_mv  = 0;
   int to24  = 0;
   int to8   = 0;
   int to8_cyc = -1;
   int mv8   = 0;

   // Reference model state, stepped as each sample is driven.
   bit m_below;
   bit m_meas;
   int m_last;
   int m_max;
   int m_min;

   function automatic int wave(input int i);
      int q;
      int j;
      q = i / 64;
      j = i % 64;
      case (q)
         0:       return 128 + 2 * j;
         1:       return 255 - 2 * j;
         2:       return 128 - 2 * j;
         default: return 2 * j;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input int d);
      sample_valid = v;
      sample_data  = 8'(d);
      if (v) begin
         if (m_below && d >= HI_T) begin
            m_below = 1'b0;
            if (m_meas)
               sb.push_back('{cyc + 1, cyc - m_last, m_max, m_min});
            m_meas = 1'b1;
            m_last = cyc;
            m_max  = d;
            m_min  = d;
         end else begin
            if (d < LO_T)
               m_below = 1'b1;
            if (m_meas) begin
               if (d > m_max) m_max = d;
               if (d < m_min) m_min = d;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 8'd0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_below = 1'b0;
      m_meas  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         drive(1'b0, 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_meas_valid"}, int'(meas_valid), 0);
      check({tag, "_timeout"},    int'(timeout), 0);
      check({tag, "_period"},     int'(period), 0);
      check({tag, "_max_val"},    int'(max_val), 0);
      check({tag, "_min_val"},    int'(min_val), 0);
   endtask

   always @(negedge clk) begin
      if (meas_valid === 1'b1) begin
         n_mv++;
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_meas: cyc=%0d period=%0d max=%0d min=%0d, none expected",
                     cyc, period, max_val, min_val);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc || e.per != int'(period) || e.mx != int'(max_val) || e.mn != int'(min_val)) begin
               n_bad++;
               $display("FAIL meas: got cyc=%0d period=%0d max=%0d min=%0d, expected cyc=%0d period=%0d max=%0d min=%0d",
                        cyc, period, max_val, min_val, e.cyc, e.per, e.mx, e.mn);
            end
         end
      end
      if (timeout === 1'b1) to24++;
      if (timeout8 === 1'b1) begin
         to8++;
         to8_cyc = cyc;
      end
      if (meas_valid8 === 1'b1) mv8++;
   end

   initial begin
      int c_ev;

      vecs[0] = '{1, 4, 1'b0, 2, 256, 255, 0};
      vecs[1] = '{4, 4, 1'b0, 2, 1024, 255, 0};
`ifdef WAVE_MEAS_HYST_EN
      vecs[2] = '{1, 3, 1'b1, 1, 256, 255, 0};
`else
      vecs[2] = '{1, 3, 1'b1, 11, 2, 129, 126};
`endif

      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 8'd0;
      @(posedge clk);
      #1;
      do_reset();
      check_zero("reset");

      for (int v = 0; v < 3; v++) begin
         do_reset();
         n_mv = 0;
         for (int r = 0; r < vecs[v].reps; r++)
            for (int i = 0; i < 256; i++)
               for (int k = 0; k < vecs[v].div; k++) begin
                  if (k == 0)
                     drive(1'b1, wave(i));
                  else
                     drive(1'b0, int'($urandom_range(255)));
               end
         if (vecs[v].tail)
            for (int t = 0; t < 20; t++)
               drive(1'b1, (t % 2 == 1) ? 129 : 126);
         idle(3);
         check($sformatf("vec%0d_meas_count", v), n_mv, vecs[v].exp_cnt);
         check($sformatf("vec%0d_period", v), int'(period), vecs[v].exp_per);
         check($sformatf("vec%0d_max_val", v), int'(max_val), vecs[v].exp_max);
         check($sformatf("vec%0d_min_val", v), int'(min_val), vecs[v].exp_min);
      end

      // Saturating 8-bit counter: one crossing, then flat mid-level.
      do_reset();
      to8 = 0;
      mv8 = 0;
      to8_cyc = -1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 256; i++)
            drive(1'b1, wave(i));
      c_ev = m_last;
      for (int t = 0; t < 300; t++)
         drive(1'b1, 128);
      check("timeout_pulses", to8, 1);
      check("timeout_cycle", to8_cyc, c_ev + 256);
      check("timeout_no_meas", mv8, 0);
      check("timeout_period_held", int'(period8), 0);

      // Reset in the middle of a measurement.
      do_reset();
      n_mv = 0;
      for (int p = 0; p < 5; p++)
         for (int i = 0; i < 256; i++) begin
            if (p == 2 && i == 100) begin
               check("pre_reset_meas_count", n_mv, 1);
               do_reset();
               check_zero("midreset");
               n_mv = 0;
            end
            drive(1'b1, wave(i));
         end
      idle(3);
      check("post_reset_meas_count", n_mv, 1);

      check("dut_timeouts", to24, 0);
      check("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
